// File: rtl/booth_r8_datapath.sv
// Sequential signed radix-8 Booth multiplier datapath: captures an operand pair on
// each start, retires one Booth digit per cycle, and publishes the product on the next start.
module booth_r8_datapath #(
  parameter int k = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [k-1:0]   a,
  input  logic [k-1:0]   b,
  output logic [2*k-1:0] product,
  output logic           valid,
  output logic           busy
);

  localparam int N  = (k + 2) / 3;
  localparam int BW = 3 * N;
  localparam int IW = $clog2(N + 1);
  localparam int PW = k + 3;
  localparam int AW = 2 * k;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [IW-1:0]         idx_r;
  logic signed [k-1:0]   a_r;
  logic signed [k+1:0]   a3_r;
  logic [BW:0]           b_sh_r;
  logic signed [AW-1:0]  acc_r;
  logic [2*k-1:0]        product_r;
  logic                  valid_r;
  logic                  busy_r;

  logic                  last_digit_s;
  logic [3:0]            win_s;
  logic                  neg_s;
  logic [2:0]            mag_s;
  logic signed [PW-1:0]  a_ext_s;
  logic signed [PW-1:0]  mult_s;
  logic signed [PW-1:0]  pp_s;
  logic signed [AW-1:0]  pp_ext_s;

  assign last_digit_s = (idx_r == IW'(N - 1));
  assign win_s        = b_sh_r[3:0];
  assign a_ext_s      = PW'(a_r);

  // Next-state logic: start always restarts, RUN ends after the last digit.
  always_comb begin
    state_s = state_r;
    if (start) begin
      state_s = RUN;
    end else begin
      case (state_r)
        IDLE:     state_s = IDLE;
        RUN:      state_s = last_digit_s ? COMPLETE : RUN;
        COMPLETE: state_s = COMPLETE;
        default:  state_s = IDLE;
      endcase
    end
  end

  // Booth recoding of the window {B[3i+2], B[3i+1], B[3i], B[3i-1]} into sign and magnitude.
  always_comb begin
    {neg_s, mag_s} = 4'b0000;
    case (win_s)
      4'b0000: {neg_s, mag_s} = 4'b0000;
      4'b0001: {neg_s, mag_s} = 4'b0001;
      4'b0010: {neg_s, mag_s} = 4'b0001;
      4'b0011: {neg_s, mag_s} = 4'b0010;
      4'b0100: {neg_s, mag_s} = 4'b0010;
      4'b0101: {neg_s, mag_s} = 4'b0011;
      4'b0110: {neg_s, mag_s} = 4'b0011;
      4'b0111: {neg_s, mag_s} = 4'b0100;
      4'b1000: {neg_s, mag_s} = 4'b1100;
      4'b1001: {neg_s, mag_s} = 4'b1011;
      4'b1010: {neg_s, mag_s} = 4'b1011;
      4'b1011: {neg_s, mag_s} = 4'b1010;
      4'b1100: {neg_s, mag_s} = 4'b1010;
      4'b1101: {neg_s, mag_s} = 4'b1001;
      4'b1110: {neg_s, mag_s} = 4'b1001;
      4'b1111: {neg_s, mag_s} = 4'b0000;
      default: {neg_s, mag_s} = 4'b0000;
    endcase
  end

  // Multiple selection and weighting by 8^i; accumulation wraps modulo 2^(2k).
  always_comb begin
    mult_s = '0;
    case (mag_s)
      3'd0:    mult_s = '0;
      3'd1:    mult_s = a_ext_s;
      3'd2:    mult_s = a_ext_s <<< 1;
      3'd3:    mult_s = PW'(a3_r);
      3'd4:    mult_s = a_ext_s <<< 2;
      default: mult_s = '0;
    endcase
    if (neg_s) begin
      pp_s = -mult_s;
    end else begin
      pp_s = mult_s;
    end
    pp_ext_s = AW'(pp_s) <<< (32'd3 * 32'(idx_r));
  end

  // State and busy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
    end
  end

  // Operand capture, digit accumulation and product retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= '0;
      a3_r      <= '0;
      b_sh_r    <= '0;
      acc_r     <= '0;
      idx_r     <= '0;
      product_r <= '0;
      valid_r   <= 1'b0;
    end else if (start) begin
      a_r    <= a;
      a3_r   <= (k+2)'(signed'(a)) + ((k+2)'(signed'(a)) <<< 1);
      b_sh_r <= {BW'(signed'(b)), 1'b0};
      acc_r  <= '0;
      idx_r  <= '0;
      if (state_r == COMPLETE) begin
        product_r <= acc_r;
        valid_r   <= 1'b1;
      end else begin
        valid_r   <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
      if (state_r == RUN) begin
        acc_r  <= acc_r + pp_ext_s;
        idx_r  <= idx_r + IW'(1);
        b_sh_r <= {{3{b_sh_r[BW]}}, b_sh_r[BW:3]};
      end
    end
  end

  assign product = product_r;
  assign valid   = valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_booth_r8_datapath.sv
// Self-checking bench for booth_r8_datapath (k=8): vector table, hand-written
// abort/late/reset sequences, and a randomized stream against an arithmetic model.
module tb_booth_r8_datapath;

  localparam int K = 8;
  localparam int N = (K + 2) / 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [K-1:0]   a = '0;
  logic [K-1:0]   b = '0;
  logic [2*K-1:0] product;
  logic           valid;
  logic           busy;

  int checks_n = 0;
  int errors_n = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[12];

  booth_r8_datapath #(.k(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic [K-1:0] av, input logic [K-1:0] bv);
    start = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [K-1:0] x, input logic [K-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  initial begin
    logic [7:0]  edge_vals[5];
    logic [15:0] last_prod;
    logic [15:0] pend_prod;
    logic        pending;
    logic        exp_valid;
    int          since;
    int          gap;
    logic [7:0]  av;
    logic [7:0]  bv;

    vt[0]  = '{8'h05, 8'h07, 16'h0023};
    vt[1]  = '{8'h80, 8'h80, 16'h4000};
    vt[2]  = '{8'h7F, 8'h80, 16'hC080};
    vt[3]  = '{8'h06, 8'hFE, 16'hFFF4};
    vt[4]  = '{8'h02, 8'h02, 16'h0004};
    vt[5]  = '{8'h00, 8'h80, 16'h0000};
    vt[6]  = '{8'hFF, 8'hFF, 16'h0001};
    vt[7]  = '{8'h7F, 8'h7F, 16'h3F01};
    vt[8]  = '{8'h01, 8'h80, 16'hFF80};
    vt[9]  = '{8'hFF, 8'h7F, 16'hFF81};
    vt[10] = '{8'hFD, 8'h05, 16'hFFF1};
    vt[11] = '{8'h80, 8'h7F, 16'hC080};
    edge_vals = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};

    // Reset state
    #12;
    check("rst_product", 32'(product), 32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table vectors streamed at the nominal period N+1
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vt[i].a, vt[i].b);
      check("tbl_valid", 32'(valid), 32'(i > 0));
      check("tbl_product", 32'(product), (i > 0) ? 32'(vt[i-1].exp) : 32'h0);
      check("tbl_busy_cap", 32'(busy), 32'h1);
      for (int j = 0; j < N; j++) begin
        step(1'b0, 8'h00, 8'h00);
        check("tbl_busy", 32'(busy), 32'(j < N - 1));
        check("tbl_valid_idle", 32'(valid), 32'h0);
      end
    end

    // Retire last vector while capturing 3x3, then abort it early with 2x2
    step(1'b1, 8'h03, 8'h03);
    check("tbl_last_valid", 32'(valid), 32'h1);
    check("tbl_last_product", 32'(product), 32'(vt[11].exp));
    step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h02, 8'h02);
    check("abort_valid", 32'(valid), 32'h0);
    check("abort_product", 32'(product), 32'(vt[11].exp));
    for (int j = 0; j < N; j++) step(1'b0, 8'h00, 8'h00);

    // On-time retire of 2x2 while capturing 6x(-2), then late retire at cycle 9
    step(1'b1, 8'h06, 8'hFE);
    check("abort_next_valid", 32'(valid), 32'h1);
    check("abort_next_product", 32'(product), 32'h0004);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 8'h00, 8'h00);
      check("late_busy", 32'(busy), 32'(c < N));
      check("late_valid", 32'(valid), 32'h0);
      check("late_hold", 32'(product), 32'h0004);
    end
    step(1'b1, 8'h09, 8'h09);
    check("late_valid_retire", 32'(valid), 32'h1);
    check("late_product", 32'(product), 32'hFFF4);

    // Asynchronous reset in cycle 2 of the 9x9 operation
    step(1'b0, 8'h00, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_product", 32'(product), 32'h0);
    check("mid_rst_valid",   32'(valid),   32'h0);
    check("mid_rst_busy",    32'(busy),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 8'h05, 8'h05);
    check("post_rst_valid0", 32'(valid), 32'h0);
    for (int j = 0; j < N; j++) begin
      step(1'b0, 8'h00, 8'h00);
      check("post_rst_novalid", 32'(valid), 32'h0);
    end
    step(1'b1, 8'h00, 8'h00);
    check("post_rst_valid", 32'(valid), 32'h1);
    check("post_rst_product", 32'(product), 32'h0019);

    // Randomized stream with random gaps (early, on-time, late, back-to-back starts)
    rst = 1'b0;
    step(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    pending   = 1'b0;
    since     = 0;
    last_prod = 16'h0000;
    pend_prod = 16'h0000;
    for (int op = 0; op < 1500; op++) begin
      gap = int'($urandom_range(N + 2, 0));
      av  = 8'($urandom);
      bv  = 8'($urandom);
      if (op % 8 == 0) begin
        av = edge_vals[$urandom_range(4, 0)];
        bv = edge_vals[$urandom_range(4, 0)];
      end
      exp_valid = pending && (since >= N);
      if (exp_valid) last_prod = pend_prod;
      step(1'b1, av, bv);
      check("rnd_valid", 32'(valid), 32'(exp_valid));
      check("rnd_product", 32'(product), 32'(last_prod));
      check("rnd_busy_cap", 32'(busy), 32'h1);
      pending   = 1'b1;
      since     = 0;
      pend_prod = ref_mul(av, bv);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 8'h00, 8'h00);
        since++;
        check("rnd_valid_idle", 32'(valid), 32'h0);
        check("rnd_busy", 32'(busy), 32'(since < N));
        check("rnd_hold", 32'(product), 32'(last_prod));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end

endmodule
